// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_pkg
// Purpose  : State and mode encodings shared by the shift sequencer files.
// Revision : 1.0  initial release
// ============================================================================
package shift_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] M_LOGIC = 2'd0;
    localparam logic [1:0] M_ARITH = 2'd1;
    localparam logic [1:0] M_ROT   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single-bit shift/rotate of a WIDTH-bit word.
// Revision : 1.0  initial release
// ============================================================================
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] w,
    input  logic             right_shift,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] w_next
);

    // Arithmetic left equals logical left; the reserved mode behaves as logical.
    always_comb begin
        w_next = {w[WIDTH-2:0], 1'b0};
        if (right_shift) begin
            if (mode == M_ARITH) begin
                w_next = {w[WIDTH-1], w[WIDTH-1:1]};
            end else if (mode == M_ROT) begin
                w_next = {w[0], w[WIDTH-1:1]};
            end else begin
                w_next = {1'b0, w[WIDTH-1:1]};
            end
        end else if (mode == M_ROT) begin
            w_next = {w[WIDTH-2:0], w[WIDTH-1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle controller performing one 1-bit shift per clock.
// Revision : 1.0  initial release
// ============================================================================
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             right_shift,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] shift_amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic [AMT_W-1:0] remaining
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_w;
    logic [AMT_W-1:0] amt_eff;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .w           (work_q),
        .right_shift (dir_q),
        .mode        (mode_q),
        .w_next      (step_w)
    );

    assign amt_eff = (shift_amount > AMT_MAX) ? AMT_MAX : shift_amount;

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
                if (start) begin
                    work_d = data_in;
                    dir_d  = right_shift;
                    mode_d = mode;
                    if (amt_eff == '0) begin
                        state_d    = S_DONE;
                        data_out_d = data_in;
                        done_d     = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                        cnt_d   = amt_eff;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                work_d = step_w;
                cnt_d  = cnt_q - AMT_ONE;
                busy_d = 1'b1;
                // The last step lands directly in the result register.
                if (cnt_q == AMT_ONE) begin
                    state_d    = S_DONE;
                    data_out_d = step_w;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            dir_q      <= 1'b0;
            mode_q     <= M_LOGIC;
            cnt_q      <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign data_out  = data_out_q;
    assign remaining = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer against a shift model.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int AMT_W = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             right_shift = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [AMT_W-1:0] shift_amount = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic [AMT_W-1:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] last_result = '0;

    shift_sequencer #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .right_shift  (right_shift),
        .mode         (mode),
        .shift_amount (shift_amount),
        .busy         (busy),
        .done         (done),
        .data_out     (data_out),
        .remaining    (remaining)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int eff_amt(input int amt);
        return (amt > WIDTH) ? WIDTH : amt;
    endfunction

    // Whole-operation result from plain shift arithmetic on the full amount.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic dir,
                                               input logic [1:0] md, input int amt);
        int n = eff_amt(amt);
        logic signed [WIDTH-1:0] s = d;
        if (md == 2'd2) begin
            if (n == 0 || n == WIDTH) return d;
            if (dir) return (d >> n) | (d << (WIDTH - n));
            return (d << n) | (d >> (WIDTH - n));
        end
        if (dir && md == 2'd1) return s >>> n;
        if (dir) return d >> n;
        return d << n;
    endfunction

    task automatic issue(input logic [WIDTH-1:0] d, input logic dir,
                         input logic [1:0] md, input int amt);
        data_in      = d;
        right_shift  = dir;
        mode         = md;
        shift_amount = AMT_W'(amt);
        start        = 1'b1;
    endtask

    // Called right after the accepting edge's inputs are set; returns in the DONE cycle.
    task automatic wait_result(input string tag, input logic [WIDTH-1:0] exp,
                               input int amt, input bit inject);
        int n = eff_amt(amt);
        bit seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1 && inject && n >= 1) begin
                issue(WIDTH'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(0, 7)));
            end else begin
                start = 1'b0;
            end
            if (done) begin
                check_eq({tag, " latency"}, k, n + 1);
                check_eq({tag, " result"}, int'(data_out), int'(exp));
                check_eq({tag, " busy_in_done"}, int'(busy), 0);
                check_eq({tag, " rem_in_done"}, int'(remaining), 0);
                last_result = exp;
                seen = 1;
                break;
            end
            check_eq({tag, " busy"}, int'(busy), 1);
            check_eq({tag, " remaining"}, int'(remaining), n - k + 1);
            check_eq({tag, " held_out"}, int'(data_out), int'(last_result));
        end
        if (!seen) check_eq({tag, " timeout"}, 0, 1);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input logic dir,
                          input logic [1:0] md, input int amt, input bit inject);
        @(negedge clock);
        issue(d, dir, md, amt);
        wait_result(tag, model(d, dir, md, amt), amt, inject);
        start = 1'b0;
        @(negedge clock);
        check_eq({tag, " done_pulse"}, int'(done), 0);
        check_eq({tag, " busy_after"}, int'(busy), 0);
        check_eq({tag, " out_held"}, int'(data_out), int'(last_result));
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             dir;
        logic [1:0]       md;
        int               amt;

        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst busy", int'(busy), 0);
        check_eq("rst done", int'(done), 0);
        check_eq("rst data_out", int'(data_out), 0);
        check_eq("rst remaining", int'(remaining), 0);

        run_op("lsl1", 4'b0101, 1'b0, 2'd0, 1, 1'b0);
        check_eq("lsl1 value", int'(data_out), int'(4'b1010));
        run_op("asr2", 4'b1100, 1'b1, 2'd1, 2, 1'b0);
        check_eq("asr2 value", int'(data_out), int'(4'b1111));
        run_op("ror3", 4'b1011, 1'b1, 2'd2, 3, 1'b0);
        check_eq("ror3 value", int'(data_out), int'(4'b0111));
        run_op("zero", 4'b1001, 1'b0, 2'd0, 0, 1'b0);
        check_eq("zero value", int'(data_out), int'(4'b1001));
        run_op("lsl7", 4'b1111, 1'b0, 2'd0, 7, 1'b0);
        check_eq("lsl7 value", int'(data_out), 0);
        run_op("rot_sat", 4'b1101, 1'b0, 2'd2, 6, 1'b0);
        run_op("asr_sat", 4'b1000, 1'b1, 2'd1, 5, 1'b0);
        run_op("rsvd", 4'b1001, 1'b1, 2'd3, 1, 1'b0);
        run_op("inject", 4'b0110, 1'b1, 2'd0, 3, 1'b1);
        check_eq("inject value", int'(data_out), int'(4'b0000));

        // Back-to-back: second request accepted straight out of DONE.
        @(negedge clock);
        issue(4'b0011, 1'b0, 2'd2, 1);
        wait_result("b2b_a", 4'b0110, 1, 1'b0);
        issue(4'b0001, 1'b0, 2'd0, 2);
        wait_result("b2b_b", 4'b0100, 2, 1'b0);
        start = 1'b0;
        @(negedge clock);

        // Reset during the 2nd SHIFT cycle of a 4-step operation.
        issue(4'b1010, 1'b0, 2'd2, 4);
        @(negedge clock);
        start = 1'b0;
        check_eq("mid busy1", int'(busy), 1);
        @(negedge clock);
        check_eq("mid busy2", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_result = '0;
        check_eq("mid rst busy", int'(busy), 0);
        check_eq("mid rst done", int'(done), 0);
        check_eq("mid rst data_out", int'(data_out), 0);
        check_eq("mid rst remaining", int'(remaining), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("mid no_done", int'(done), 0);
        end
        run_op("after_rst", 4'b0111, 1'b1, 2'd0, 2, 1'b0);

        // Randomized operations, some chained back-to-back, some with stray starts.
        for (int i = 0; i < 60; i++) begin
            d   = WIDTH'($urandom);
            dir = 1'($urandom);
            md  = 2'($urandom);
            amt = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                issue(d, dir, md, amt);
                wait_result("rnd_chain", model(d, dir, md, amt), amt, 1'b0);
                start = 1'b0;
            end else begin
                run_op("rnd", d, dir, md, amt, 1'($urandom));
            end
        end

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
